// File: rtl/byte_lsu_seq_pkg.sv
// Shared definitions for the byte-serial load/store unit: memory size,
// func3 access encodings, FSM state encoding and small decode helpers.
package byte_lsu_seq_pkg;

    localparam int LSU_ADDR_W   = 12;
    localparam int LSU_MEM_SIZE = 1 << LSU_ADDR_W;

    // func3 encodings of the supported accesses
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Byte lane k (0..3) of a 32-bit word, little-endian.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Number of bytes in the access, minus one.
    function automatic logic [1:0] nbytes_m1(input logic [2:0] func3);
        logic [1:0] n;
        case (func3[1:0])
            2'd1:    n = 2'd1;
            2'd2:    n = 2'd3;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Legal func3 for the access direction; stores have no unsigned forms.
    function automatic logic is_legal(input logic we, input logic [2:0] func3);
        logic ok;
        case (func3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural-alignment test on the two low address bits.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic mis;
        case (func3[1:0])
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/byte_lsu_seq_load_ext.sv
// Load-result extension: sign/zero extends the assembled little-endian
// word according to func3. Purely combinational.
module lsu_load_ext
    import byte_lsu_seq_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_word,
    output logic [31:0] o_ext
);

    // Select extension from the access size and signedness
    always_comb begin
        // NOTE: default assignment first so every path drives o_ext and no latch is inferred.
        o_ext = i_word;
        case (i_func3)
            F3_B:    o_ext = {{24{i_word[7]}}, i_word[7:0]};
            F3_H:    o_ext = {{16{i_word[15]}}, i_word[15:0]};
            F3_BU:   o_ext = {24'h0, i_word[7:0]};
            F3_HU:   o_ext = {16'h0, i_word[15:0]};
            default: o_ext = i_word;
        endcase
    end

endmodule

// File: rtl/byte_lsu_seq.sv
// Byte-serial load/store initiator. Accepts one func3-encoded request,
// walks it one byte per cycle over a byte-wide memory port and returns the
// extended load data. Optional macro LSU_MISALIGN_TRAP_EN rejects
// misaligned halfword/word accesses instead of performing them byte-wise.
module byte_lsu_seq
    import byte_lsu_seq_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        r_state;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [31:0]       r_wdata;
    logic [2:0]        r_func3;
    logic [1:0]        r_idx;
    logic [1:0]        r_last;
    logic [31:0]       r_word;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_reject;
    logic [31:0]       w_word_next;
    logic [31:0]       w_ext;

    assign w_accept = req_valid & r_req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = is_misaligned(req_func3, req_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = ~is_legal(req_we, req_func3) | w_misaligned;

    // Merge the byte currently on mem_rdata into its lane of the load word
    always_comb begin
        w_word_next = r_word;
        case (r_idx)
            2'd0:    w_word_next[7:0]   = mem_rdata;
            2'd1:    w_word_next[15:8]  = mem_rdata;
            2'd2:    w_word_next[23:16] = mem_rdata;
            default: w_word_next[31:24] = mem_rdata;
        endcase
    end

    lsu_load_ext u_load_ext (
        .i_func3 (r_func3),
        .i_word  (w_word_next),
        .o_ext   (w_ext)
    );

    // Request FSM with registered handshake, response and memory strobes.
    // A rejected request spends one strobe-free cycle in ACCESS so that its
    // response lands with the same timing as a single-byte access.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state flop, including the byte assembly register, is reset so an aborted access leaves nothing behind.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_addr       <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_wdata      <= '0;
            r_func3      <= '0;
            r_idx        <= '0;
            r_last       <= '0;
            r_word       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_ACCESS;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_resp_err  <= w_reject;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_func3     <= req_func3;
                        r_idx       <= '0;
                        r_last      <= w_reject ? 2'd0 : nbytes_m1(req_func3);
                        r_word      <= '0;
                        r_mem_re    <= ~w_reject & ~req_we;
                        r_mem_we    <= ~w_reject & req_we;
                    end
                end

                ST_ACCESS: begin
                    if (r_mem_re) begin
                        r_word <= w_word_next;
                    end
                    if (r_idx == r_last) begin
                        r_state      <= ST_RESP;
                        r_mem_re     <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_mem_re ? w_ext : 32'h0;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_wdata <= {8'h00, r_wdata[31:8]};
                    end
                end

                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_busy       <= 1'b0;
                    r_req_ready  <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_mem_re    <= 1'b0;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_valid & r_resp_err;
    assign mem_addr   = r_addr;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = byte_lane(r_wdata, 2'd0);

endmodule

// File: tb/tb_byte_lsu_seq.sv
// Self-checking bench for byte_lsu_seq: directed vector table, a reset
// abort sequence and randomized requests against a byte-array model.
module tb_byte_lsu_seq;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    byte_lsu_seq #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide data memory: combinational read, write on rising edge.
    logic [7:0] mem [0:4095];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Reference model state: what memory should contain.
    logic [7:0] model_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [11:0] addr);
        bit err;
        err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
        if (TRAP_EN && !err) begin
            if (nbytes(f3) == 2 && (addr % 2) != 0) err = 1'b1;
            if (nbytes(f3) == 4 && (addr % 4) != 0) err = 1'b1;
        end
        return err;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [11:0] addr);
        logic [31:0] val;
        logic [11:0] a;
        val = 0;
        for (int i = 0; i < nbytes(f3); i++) begin
            a = addr + 12'(i);
            val = val | (32'(model_mem[a]) << (8 * i));
        end
        if (f3 == 0 && val >= 32'h80)   val = val | 32'hFFFF_FF00;
        if (f3 == 1 && val >= 32'h8000) val = val | 32'hFFFF_0000;
        return val;
    endfunction

    // Issue one request and check strobes, timing, response and handshake.
    task automatic do_req(input string name, input bit we, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err);
        int          k;
        int          n;
        int          exp_lat;
        int          bad;
        bit          exp_re;
        bit          exp_we;
        logic [11:0] exp_a;
        logic [31:0] sh;
        n       = nbytes(f3);
        exp_lat = exp_err ? 2 : n + 1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble request fields to make sure they were registered at accept.
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_func3 = 3'($urandom);
        req_addr  = 12'($urandom);
        req_wdata = $urandom;
        k   = 1;
        bad = 0;
        while (!resp_valid && k <= 12) begin
            exp_re = 1'b0;
            exp_we = 1'b0;
            exp_a  = addr + 12'(k - 1);
            if (!exp_err && k <= n) begin
                exp_re = !we;
                exp_we = we;
            end
            if (mem_re !== exp_re || mem_we !== exp_we) bad++;
            if ((exp_re || exp_we) && mem_addr !== exp_a) bad++;
            if (exp_we) begin
                sh = wdata >> (8 * (k - 1));
                if (mem_wdata !== sh[7:0]) bad++;
            end
            if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        if (!resp_valid) return;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) bad++;
        check({name, "_rdata"}, 64'(resp_rdata), 64'(exp_rdata));
        check({name, "_err"}, 64'(resp_err), 64'(exp_err));
        check({name, "_strobes"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({name, "_after"}, {61'd0, req_ready, busy, resp_valid}, 64'b100);
        if (we && !exp_err) begin
            for (int i = 0; i < n; i++) begin
                sh = wdata >> (8 * i);
                model_mem[addr + 12'(i)] = sh[7:0];
            end
        end
    endtask

    typedef struct {
        string       name;
        bit          we;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          e;
        int          sel;

        for (int i = 0; i < 4096; i++) begin
            mem[i]       = 8'h00;
            model_mem[i] = 8'h00;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'd0;
        req_addr  = 12'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outs_in_reset",
              {7'd0, resp_valid, resp_rdata, resp_err, busy, mem_addr, mem_re, mem_we, mem_wdata},
              64'd0);
        check("reset_ready_in_reset", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs_after",
              {7'd0, resp_valid, resp_rdata, resp_err, busy, mem_addr, mem_re, mem_we, mem_wdata},
              64'd0);
        check("reset_ready_after", 64'(req_ready), 64'd1);

        // Directed vectors
        vecs.push_back('{"sw_010",   1, 3'd2, 12'h010, 32'h8899AABB, 32'h0, 0});
        vecs.push_back('{"sb_010",   1, 3'd0, 12'h010, 32'h00000080, 32'h0, 0});
        vecs.push_back('{"sb_011",   1, 3'd0, 12'h011, 32'h0000007F, 32'h0, 0});
        vecs.push_back('{"lb_010",   0, 3'd0, 12'h010, 32'h0, 32'hFFFFFF80, 0});
        vecs.push_back('{"lbu_010",  0, 3'd4, 12'h010, 32'h0, 32'h00000080, 0});
        vecs.push_back('{"lb_011",   0, 3'd0, 12'h011, 32'h0, 32'h0000007F, 0});
        vecs.push_back('{"sb_011b",  1, 3'd0, 12'h011, 32'h000000AA, 32'h0, 0});
        vecs.push_back('{"sb_012",   1, 3'd0, 12'h012, 32'h00000099, 32'h0, 0});
        vecs.push_back('{"lh_011",   0, 3'd1, 12'h011, 32'h0, TRAP_EN ? 32'h0 : 32'hFFFF99AA, TRAP_EN});
        vecs.push_back('{"lhu_011",  0, 3'd5, 12'h011, 32'h0, TRAP_EN ? 32'h0 : 32'h000099AA, TRAP_EN});
        vecs.push_back('{"lw_010",   0, 3'd2, 12'h010, 32'h0, 32'h8899AA80, 0});
        vecs.push_back('{"sh_fff",   1, 3'd1, 12'hFFF, 32'h00001234, 32'h0, TRAP_EN});
        vecs.push_back('{"lhu_fff",  0, 3'd5, 12'hFFF, 32'h0, TRAP_EN ? 32'h0 : 32'h00001234, TRAP_EN});
        vecs.push_back('{"ld_f3_3",  0, 3'd3, 12'h020, 32'h0, 32'h0, 1});
        vecs.push_back('{"st_f3_5",  1, 3'd5, 12'h020, 32'h12345678, 32'h0, 1});
        vecs.push_back('{"ld_f3_7",  0, 3'd7, 12'h020, 32'h0, 32'h0, 1});

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end
        if (!TRAP_EN) begin
            check("sh_fff_mem_fff", 64'(mem[12'hFFF]), 64'h34);
            check("sh_fff_mem_000", 64'(mem[12'h000]), 64'h12);
        end

        // Reset asserted while byte 2 of a word store is on the port
        do_req("sw_100_clear", 1, 3'd2, 12'h100, 32'h0, 32'h0, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_func3 = 3'd2;
        req_addr  = 12'h100;
        req_wdata = 32'hDDCCBBAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outs_in_reset",
              {7'd0, resp_valid, resp_rdata, resp_err, busy, mem_addr, mem_re, mem_we, mem_wdata},
              64'd0);
        check("abort_ready_in_reset", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem_100", 64'(mem[12'h100]), 64'hAA);
        check("abort_mem_101", 64'(mem[12'h101]), 64'hBB);
        check("abort_mem_102", 64'(mem[12'h102]), 64'h00);
        check("abort_mem_103", 64'(mem[12'h103]), 64'h00);
        model_mem[12'h100] = 8'hAA;
        model_mem[12'h101] = 8'hBB;
        @(negedge clk);
        do_req("lw_100_after_abort", 0, 3'd2, 12'h100, 32'h0, 32'h0000BBAA, 0);

        // Randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            we  = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            case (sel)
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                4: f3 = 3'd5;
                5, 6: f3 = 3'd2;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            addr  = $urandom_range(0, 1) ? 12'($urandom_range(0, 15))
                                         : 12'hFF8 + 12'($urandom_range(0, 7));
            wdata = $urandom;
            e     = model_err(we, f3, addr);
            do_req($sformatf("rand%0d", i), we, f3, addr, wdata,
                   (e || we) ? 32'h0 : model_load(f3, addr), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
